// File: rtl/oclib_threshold_monitor_pkg.sv
// oclib_threshold_monitor_pkg
// Shared types and constants for the threshold monitor.
//   stateT        : 3-bit FSM state encoding (IDLE=0 .. LOW=5), also exported on the debug port
//   PersistZeroAs : effective persistence used when persistCount is programmed to 0
package oclib_threshold_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NORMAL    = 3'd1,
    PEND_HIGH = 3'd2,
    HIGH      = 3'd3,
    PEND_LOW  = 3'd4,
    LOW       = 3'd5
  } stateT;

  // A persistence of 0 would never trip; treat it as "trip on the first sample".
  localparam int PersistZeroAs = 1;

endpackage

// File: rtl/oclib_persist_counter.sv
// oclib_persist_counter
// Saturating consecutive-sample counter shared by the PEND_HIGH/PEND_LOW states.
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   clr           : zero the count (wins over inc)
//   inc           : advance the count by one, saturating at all ones
//   persistCount  : programmed persistence (0 behaves as 1)
//   hit           : the count after this increment reaches the effective persistence
module oclib_persist_counter
  import oclib_threshold_monitor_pkg::*;
#(
  parameter int CountWidth = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [CountWidth-1:0] persistCount,
  output logic                  hit
);

  logic [CountWidth-1:0] count, countInc, effPersist;

  assign countInc   = (&count) ? count : count + 1'b1;
  assign effPersist = (persistCount == '0) ? CountWidth'(PersistZeroAs) : persistCount;
  // >= rather than == so a persistCount lowered mid-pend trips on the next compare.
  assign hit        = (countInc >= effPersist);

  always_ff @(posedge clock) begin
    if (reset)    count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= countInc;
  end

endmodule

// File: rtl/oclib_threshold_monitor.sv
// oclib_threshold_monitor
// Debounced high/low alarm on a smoothed value, with persistence and hysteresis.
// Optional peak tracking is compiled in with `define OC_THRESHOLD_MONITOR_PEAK_EN.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   in, inValid                  : averaged sample and its qualifier
//   thresholdHigh/thresholdLow   : trip levels (in > high, in < low)
//   hysteresis                   : release margin below high / above low
//   persistCount                 : consecutive qualifying samples to trip (0 == 1)
//   clear                        : clears sticky flags (and peaks)
//   alarmHigh/alarmLow           : live alarms
//   stickyHigh/stickyLow         : latched trip events
//   state                        : FSM state for debug
//   peakMax/peakMin              : sample extremes (constants when peaks are not built)
module oclib_threshold_monitor
  import oclib_threshold_monitor_pkg::*;
#(
  parameter int Width      = 9,
  parameter int CountWidth = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [Width-1:0]      in,
  input  logic                  inValid,
  input  logic [Width-1:0]      thresholdHigh,
  input  logic [Width-1:0]      thresholdLow,
  input  logic [Width-1:0]      hysteresis,
  input  logic [CountWidth-1:0] persistCount,
  input  logic                  clear,
  output logic                  alarmHigh,
  output logic                  alarmLow,
  output logic                  stickyHigh,
  output logic                  stickyLow,
  output logic [2:0]            state,
  output logic [Width-1:0]      peakMax,
  output logic [Width-1:0]      peakMin
);

  stateT stateQ, stateNext, evalState;
  logic cntClr, cntInc, hit;
  logic aboveHigh, belowLow;
  logic alarmHighNext, alarmLowNext, setHigh, setLow;
  logic [Width:0] relHighWide, relLowWide;
  logic [Width-1:0] relHigh, relLow;

  // Release levels computed one bit wider and clamped into range.
  assign relHighWide = {1'b0, thresholdHigh} - {1'b0, hysteresis};
  assign relLowWide  = {1'b0, thresholdLow}  + {1'b0, hysteresis};
  assign relHigh     = relHighWide[Width] ? '0 : relHighWide[Width-1:0];
  assign relLow      = relLowWide[Width]  ? '1 : relLowWide[Width-1:0];

  assign aboveHigh = (in > thresholdHigh);
  assign belowLow  = (in < thresholdLow);

  oclib_persist_counter #(.CountWidth(CountWidth)) uCounter (
    .clock        (clock),
    .reset        (reset),
    .clr          (cntClr),
    .inc          (cntInc),
    .persistCount (persistCount),
    .hit          (hit)
  );

  always_ff @(posedge clock) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateNext;
  end

  always_comb begin
    stateNext = stateQ;
    cntClr    = 1'b0;
    cntInc    = 1'b0;
    // The first valid sample out of IDLE is judged as if already in NORMAL.
    evalState = (stateQ == IDLE) ? NORMAL : stateQ;
    if (inValid) begin
      case (evalState)
        NORMAL: begin
          stateNext = NORMAL;
          if (aboveHigh || belowLow) begin  // high has priority on inverted thresholds
            if (hit) begin
              stateNext = aboveHigh ? HIGH : LOW;
              cntClr    = 1'b1;
            end else begin
              stateNext = aboveHigh ? PEND_HIGH : PEND_LOW;
              cntInc    = 1'b1;
            end
          end
        end
        PEND_HIGH: begin
          if (!aboveHigh)  begin stateNext = NORMAL; cntClr = 1'b1; end
          else if (hit)    begin stateNext = HIGH;   cntClr = 1'b1; end
          else             cntInc = 1'b1;
        end
        PEND_LOW: begin
          if (!belowLow)   begin stateNext = NORMAL; cntClr = 1'b1; end
          else if (hit)    begin stateNext = LOW;    cntClr = 1'b1; end
          else             cntInc = 1'b1;
        end
        HIGH:    if (in < relHigh) stateNext = NORMAL;
        LOW:     if (in > relLow)  stateNext = NORMAL;
        default: begin stateNext = IDLE; cntClr = 1'b1; end
      endcase
    end
  end

  always_comb begin
    alarmHighNext = (stateNext == HIGH);
    alarmLowNext  = (stateNext == LOW);
    setHigh       = (stateNext == HIGH) && (stateQ != HIGH);
    setLow        = (stateNext == LOW)  && (stateQ != LOW);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alarmHigh  <= 1'b0;
      alarmLow   <= 1'b0;
      stickyHigh <= 1'b0;
      stickyLow  <= 1'b0;
    end else begin
      alarmHigh  <= alarmHighNext;
      alarmLow   <= alarmLowNext;
      // Set beats a coincident clear.
      stickyHigh <= setHigh | (stickyHigh & ~clear);
      stickyLow  <= setLow  | (stickyLow  & ~clear);
    end
  end

  assign state = stateQ;

`ifdef OC_THRESHOLD_MONITOR_PEAK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      peakMax <= '0;
      peakMin <= '1;
    end else if (clear) begin
      peakMax <= inValid ? in : '0;
      peakMin <= inValid ? in : '1;
    end else if (inValid) begin
      if (in > peakMax) peakMax <= in;
      if (in < peakMin) peakMin <= in;
    end
  end
`else
  assign peakMax = '0;
  assign peakMin = '1;
`endif

endmodule

// File: tb/tb_oclib_threshold_monitor.sv
module tb_oclib_threshold_monitor;
  import oclib_threshold_monitor_pkg::*;

  localparam int W = 9;
  localparam int C = 8;

  logic clock, reset, inValid, clear;
  logic [W-1:0] in, thresholdHigh, thresholdLow, hysteresis;
  logic [C-1:0] persistCount;
  logic alarmHigh, alarmLow, stickyHigh, stickyLow;
  logic [2:0] state;
  logic [W-1:0] peakMax, peakMin;

  oclib_threshold_monitor #(.Width(W), .CountWidth(C)) dut (
    .clock(clock), .reset(reset), .in(in), .inValid(inValid),
    .thresholdHigh(thresholdHigh), .thresholdLow(thresholdLow),
    .hysteresis(hysteresis), .persistCount(persistCount), .clear(clear),
    .alarmHigh(alarmHigh), .alarmLow(alarmLow), .stickyHigh(stickyHigh),
    .stickyLow(stickyLow), .state(state), .peakMax(peakMax), .peakMin(peakMin)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic         rst, vld, clr;
    logic [W-1:0] din, thH, thL, hyst;
    logic [C-1:0] pers;
    logic [6:0]   exp;   // {state, alarmHigh, alarmLow, stickyHigh, stickyLow}
  } vecT;

  typedef struct {
    logic [6:0] exp;
    logic       chkPeak;
    int         idx;
  } sbT;

  vecT vecs[$];
  sbT  expQ[$];
  int  nChecks = 0;
  int  nFails  = 0;
  int  vecIdx  = 0;

  function automatic vecT mk(input logic rst, vld, input int din, input logic clr,
                             input int thH, thL, hyst, pers,
                             input stateT st, input logic ah, al, sh, sl);
    vecT v;
    v.rst = rst; v.vld = vld; v.din = W'(din); v.clr = clr;
    v.thH = W'(thH); v.thL = W'(thL); v.hyst = W'(hyst); v.pers = C'(pers);
    v.exp = {st, ah, al, sh, sl};
    return v;
  endfunction

  task automatic check();
    sbT e;
    if (expQ.size() == 0) begin
      nChecks++; nFails++;
      $display("FAIL scoreboard_empty vec=%0d", vecIdx);
      return;
    end
    e = expQ.pop_front();
    nChecks++;
    if ({state, alarmHigh, alarmLow, stickyHigh, stickyLow} !== e.exp) begin
      nFails++;
      $display("FAIL vec%0d {state,aH,aL,sH,sL} got=%0d,%b,%b,%b,%b want=%0d,%b,%b,%b,%b",
               e.idx, state, alarmHigh, alarmLow, stickyHigh, stickyLow,
               e.exp[6:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
    end
    if (e.chkPeak) begin
      nChecks++;
      if (peakMax !== '0 || peakMin !== '1) begin
        nFails++;
        $display("FAIL vec%0d reset_peaks got max=%0d min=%0d want max=0 min=511",
                 e.idx, peakMax, peakMin);
      end
    end
  endtask

  task automatic applyVec(input vecT v);
    sbT e;
    @(negedge clock);
    reset = v.rst; inValid = v.vld; in = v.din; clear = v.clr;
    thresholdHigh = v.thH; thresholdLow = v.thL; hysteresis = v.hyst;
    persistCount = v.pers;
    e.exp = v.exp; e.chkPeak = v.rst; e.idx = vecIdx;
    expQ.push_back(e);
    @(posedge clock);
    #1;
    check();
    vecIdx++;
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; clear = 1'b0; in = '0;
    thresholdHigh = W'(300); thresholdLow = W'(50); hysteresis = W'(20);
    persistCount = C'(3);

    // Reset and idle
    vecs.push_back(mk(1,0,0,0, 300,50,20,3, IDLE,0,0,0,0));
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk(0,0,0,0, 300,50,20,3, IDLE,0,0,0,0));
    // High trip, persist 3
    vecs.push_back(mk(0,1,301,0, 300,50,20,3, PEND_HIGH,0,0,0,0));
    vecs.push_back(mk(0,1,302,0, 300,50,20,3, PEND_HIGH,0,0,0,0));
    vecs.push_back(mk(0,1,303,0, 300,50,20,3, HIGH,1,0,1,0));
    // Hysteresis release at 280
    vecs.push_back(mk(0,1,285,0, 300,50,20,3, HIGH,1,0,1,0));
    vecs.push_back(mk(0,1,279,0, 300,50,20,3, NORMAL,0,0,1,0));
    // Debounce: break resets the count; gaps keep it
    vecs.push_back(mk(0,1,301,0, 300,50,20,3, PEND_HIGH,0,0,1,0));
    vecs.push_back(mk(0,1,301,0, 300,50,20,3, PEND_HIGH,0,0,1,0));
    vecs.push_back(mk(0,1,250,0, 300,50,20,3, NORMAL,0,0,1,0));
    vecs.push_back(mk(0,1,301,0, 300,50,20,3, PEND_HIGH,0,0,1,0));
    vecs.push_back(mk(0,1,301,0, 300,50,20,3, PEND_HIGH,0,0,1,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,301,0, 300,50,20,3, PEND_HIGH,0,0,1,0));
    vecs.push_back(mk(0,1,301,0, 300,50,20,3, HIGH,1,0,1,0));
    // Clear with no set; alarm stays
    vecs.push_back(mk(0,0,0,1, 300,50,20,3, HIGH,1,0,0,0));
    vecs.push_back(mk(0,1,200,0, 300,50,20,3, NORMAL,0,0,0,0));
    // Clear collides with entry into LOW, persist 0 acts as 1
    vecs.push_back(mk(0,1,10,1, 300,50,20,0, LOW,0,1,0,1));
    // Release level clamps at 511: cannot leave LOW
    vecs.push_back(mk(0,1,511,0, 300,500,100,0, LOW,0,1,0,1));
    vecs.push_back(mk(0,1,0,0, 300,500,100,0, LOW,0,1,0,1));
    vecs.push_back(mk(0,1,71,0, 300,50,20,0, NORMAL,0,0,0,1));
    // Inverted thresholds: high wins
    vecs.push_back(mk(0,1,150,0, 100,200,20,1, HIGH,1,0,1,1));
    // Threshold raised while HIGH: only release compare (380) applies
    vecs.push_back(mk(0,1,390,0, 400,50,20,1, HIGH,1,0,1,1));
    // Reset mid-operation overrides inValid/clear
    vecs.push_back(mk(1,1,390,1, 400,50,20,1, IDLE,0,0,0,0));
    // First sample out of IDLE evaluated immediately
    vecs.push_back(mk(0,1,450,0, 400,50,20,1, HIGH,1,0,1,0));
    vecs.push_back(mk(0,1,379,0, 400,50,20,2, NORMAL,0,0,1,0));
    // Equal to threshold does not trip
    vecs.push_back(mk(0,1,400,0, 400,50,20,2, NORMAL,0,0,1,0));
    vecs.push_back(mk(0,1,50,0,  400,50,20,2, NORMAL,0,0,1,0));
    // Low trip, persist 2
    vecs.push_back(mk(0,1,40,0, 400,50,20,2, PEND_LOW,0,0,1,0));
    vecs.push_back(mk(0,1,40,0, 400,50,20,2, LOW,0,1,1,1));

    foreach (vecs[i]) applyVec(vecs[i]);

    // Hand sequence: clears while parked in LOW, then release
    applyVec(mk(0,0,0,1,   300,50,20,3, LOW,0,1,0,0));
    applyVec(mk(0,1,40,0,  300,50,20,3, LOW,0,1,0,0));
    applyVec(mk(0,1,40,1,  300,50,20,3, LOW,0,1,0,0));
    applyVec(mk(0,1,70,0,  300,50,20,3, LOW,0,1,0,0));
    applyVec(mk(0,1,100,0, 300,50,20,3, NORMAL,0,0,0,0));
    // Hand sequence: PEND_LOW broken by a high sample is not re-judged as high
    applyVec(mk(0,1,40,0,  300,50,20,3, PEND_LOW,0,0,0,0));
    applyVec(mk(0,1,350,0, 300,50,20,3, NORMAL,0,0,0,0));
    applyVec(mk(0,1,350,0, 300,50,20,1, HIGH,1,0,1,0));

    if (expQ.size() != 0) begin
      nChecks++; nFails++;
      $display("FAIL scoreboard_leftover got=%0d want=0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
